// File: rtl/fastram_autoconfig.sv
// Zorro II AutoConfig controller for the on-board fast RAM: serves the config
// ROM nibbles at $E8xxxx and takes the base-address or shut-up write.
module fastram_autoconfig #(
  parameter logic [15:0] MANUFACTURER = 16'h07DB,
  parameter logic [7:0]  PRODUCT      = 8'h06,
  parameter logic [31:0] SERIAL       = 32'h00000000
) (
  input  logic         CLK,
  input  logic         RESET_n,
  input  logic [23:1]  A,
  input  logic         RW_n,
  input  logic         AS_n,
  input  logic         DS_n,
  input  logic [15:12] D_IN,
  input  logic         JP2,
  input  logic         CONFIG_IN_n,
  output logic [15:12] D_OUT,
  output logic         D_OE,
  output logic         DTACK_n,
  output logic [7:5]   BASE_RAM,
  output logic         RAM_CONFIGURED_n,
  output logic         CONFIG_OUT_n
);

  typedef enum logic [1:0] {CFG_UNCONF, CFG_CONFIGURED, CFG_SHUTUP} cfg_t;
  typedef enum logic [1:0] {CYC_IDLE, CYC_ACK, CYC_WAIT_END} cyc_t;

  cfg_t       cfg_state, cfg_next;
  cyc_t       cyc_state, cyc_next;
  logic [1:0] as_sync, ds_sync, rw_sync;
  logic       as_s, ds_s, rw_s;
  logic       hit, start, read_cyc;
  logic [6:0] offset;
  logic [7:0] er_type;
  logic [3:0] rom_data, d_out_q;
  logic [2:0] base_q;
  logic       unused_bits;

  assign as_s        = as_sync[1];
  assign ds_s        = ds_sync[1];
  assign rw_s        = rw_sync[1];
  assign offset      = {A[6:1], 1'b0};
  assign hit         = !as_s && (A[23:16] == 8'hE8) && !CONFIG_IN_n && (cfg_state == CFG_UNCONF);
  assign start       = (cyc_state == CYC_IDLE) && hit && !ds_s;
  assign unused_bits = ^{A[15:7], D_IN[12]};

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      as_sync <= 2'b11;
      ds_sync <= 2'b11;
      rw_sync <= 2'b11;
    end else begin
      as_sync <= {as_sync[0], AS_n};
      ds_sync <= {ds_sync[0], DS_n};
      rw_sync <= {rw_sync[0], RW_n};
    end
  end

  // Nibble index is A[6:1]; only er_Type and the $40+ range are not inverted.
  always_comb begin
    er_type  = {2'b11, 1'b1, 2'b00, (JP2 ? 3'b000 : 3'b111)};
    rom_data = A[6] ? 4'h0 : 4'hF;
    case (A[6:1])
      6'd0:    rom_data = er_type[7:4];
      6'd1:    rom_data = er_type[3:0];
      6'd2:    rom_data = ~PRODUCT[7:4];
      6'd3:    rom_data = ~PRODUCT[3:0];
      6'd8:    rom_data = ~MANUFACTURER[15:12];
      6'd9:    rom_data = ~MANUFACTURER[11:8];
      6'd10:   rom_data = ~MANUFACTURER[7:4];
      6'd11:   rom_data = ~MANUFACTURER[3:0];
      6'd12:   rom_data = ~SERIAL[31:28];
      6'd13:   rom_data = ~SERIAL[27:24];
      6'd14:   rom_data = ~SERIAL[23:20];
      6'd15:   rom_data = ~SERIAL[19:16];
      6'd16:   rom_data = ~SERIAL[15:12];
      6'd17:   rom_data = ~SERIAL[11:8];
      6'd18:   rom_data = ~SERIAL[7:4];
      6'd19:   rom_data = ~SERIAL[3:0];
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      cyc_state <= CYC_IDLE;
      cfg_state <= CFG_UNCONF;
    end else begin
      cyc_state <= cyc_next;
      cfg_state <= cfg_next;
    end
  end

  always_comb begin
    cyc_next = cyc_state;
    cfg_next = cfg_state;
    case (cyc_state)
      CYC_IDLE: begin
        if (start) begin
          cyc_next = CYC_ACK;
          if (!rw_s) begin
            if (offset == 7'h48)
              cfg_next = CFG_CONFIGURED;
            else if (offset == 7'h4C)
              cfg_next = CFG_SHUTUP;
          end
        end
      end
      CYC_ACK:      cyc_next = CYC_WAIT_END;
      CYC_WAIT_END: if (as_s) cyc_next = CYC_IDLE;
      default:      cyc_next = CYC_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      d_out_q  <= '0;
      base_q   <= '0;
      read_cyc <= 1'b0;
    end else if (start) begin
      read_cyc <= rw_s;
      if (rw_s)
        d_out_q <= rom_data;
      else if (offset == 7'h48)
        base_q <= D_IN[15:13];
    end
  end

  always_comb begin
    D_OUT            = d_out_q;
    BASE_RAM         = base_q;
    D_OE             = read_cyc && (cyc_state != CYC_IDLE);
    DTACK_n          = (cyc_state != CYC_WAIT_END);
    CONFIG_OUT_n     = (cfg_state == CFG_UNCONF);
    RAM_CONFIGURED_n = (cfg_state != CFG_CONFIGURED);
  end

endmodule

// File: tb/tb_fastram_autoconfig.sv
// Bench for fastram_autoconfig: directed and random bus cycles checked against
// a register-level model of the AutoConfig space and board state.
module tb_fastram_autoconfig;

  localparam logic [15:0] TB_MANUF  = 16'h07DB;
  localparam logic [7:0]  TB_PROD   = 8'h06;
  localparam logic [31:0] TB_SERIAL = 32'h1234_5678;

  logic        CLK, RESET_n, RW_n, AS_n, DS_n, JP2, CONFIG_IN_n;
  logic [23:1] A;
  logic [3:0]  D_IN, D_OUT;
  logic        D_OE, DTACK_n, RAM_CONFIGURED_n, CONFIG_OUT_n;
  logic [2:0]  BASE_RAM;

  int          total = 0;
  int          bad   = 0;
  int          m_cfg;      // 0 unconfigured, 1 configured, 2 shut up
  logic [2:0]  m_base;

  fastram_autoconfig #(
    .MANUFACTURER(TB_MANUF),
    .PRODUCT(TB_PROD),
    .SERIAL(TB_SERIAL)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .A(A), .RW_n(RW_n), .AS_n(AS_n), .DS_n(DS_n),
    .D_IN(D_IN), .JP2(JP2), .CONFIG_IN_n(CONFIG_IN_n), .D_OUT(D_OUT), .D_OE(D_OE),
    .DTACK_n(DTACK_n), .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n),
    .CONFIG_OUT_n(CONFIG_OUT_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register bytes sit at 4-byte spacing, high nibble at +0, low nibble at +2.
  function automatic logic [3:0] exp_nibble(input int off, input logic jp2);
    logic [7:0]  b;
    logic [3:0]  v;
    logic [31:0] ser;
    logic [15:0] man;
    int          reg_off;
    ser = TB_SERIAL;
    man = TB_MANUF;
    if (off >= 'h40) return 4'h0;
    reg_off = off & 'h7C;
    case (reg_off)
      'h00:    b = jp2 ? 8'hE0 : 8'hE7;
      'h04:    b = TB_PROD;
      'h10:    b = man[15:8];
      'h14:    b = man[7:0];
      'h18:    b = ser[31:24];
      'h1C:    b = ser[23:16];
      'h20:    b = ser[15:8];
      'h24:    b = ser[7:0];
      default: b = 8'h00;
    endcase
    v = ((off & 2) != 0) ? b[3:0] : b[7:4];
    return (reg_off == 0) ? v : ~v;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RESET_n = 1'b0; AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
    m_cfg  = 0;
    m_base = 3'b000;
  endtask

  // Edge counts are relative to strobe assertion / release; 0 means never seen.
  task automatic bus_cycle(input logic [23:0] addr, input logic rd, input logic [3:0] wdata,
                           input logic drop, output int oe_e, output int dt_e,
                           output int cfg_e, output logic [3:0] dout, output int rel_e);
    @(negedge CLK);
    A = addr[23:1]; RW_n = rd; D_IN = wdata; AS_n = 1'b0; DS_n = 1'b0;
    oe_e = 0; dt_e = 0; cfg_e = 0; rel_e = 0; dout = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      if (D_OE && oe_e == 0) begin oe_e = i; dout = D_OUT; end
      if (!DTACK_n && dt_e == 0) dt_e = i;
      if (!CONFIG_OUT_n && cfg_e == 0) cfg_e = i;
      if (drop && oe_e != 0) CONFIG_IN_n = 1'b1;
    end
    @(negedge CLK);
    AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      if (DTACK_n && !D_OE && rel_e == 0) rel_e = i;
    end
  endtask

  task automatic txn(input string tag, input logic [23:0] addr, input logic rd,
                     input logic [3:0] d, input logic drop);
    int oe_e, dt_e, cfg_e, rel_e, off;
    logic [3:0] dout;
    logic resp;
    resp = (m_cfg == 0) && !CONFIG_IN_n && (addr[23:16] == 8'hE8);
    off  = int'(addr[6:0]) & 'h7E;
    bus_cycle(addr, rd, d, drop, oe_e, dt_e, cfg_e, dout, rel_e);
    check({tag, ".oe_edge"}, oe_e, (rd && resp) ? 3 : 0);
    check({tag, ".dtack_edge"}, dt_e, resp ? 4 : 0);
    check({tag, ".release_edge"}, rel_e, resp ? 3 : 1);
    if (rd && resp) check({tag, ".d_out"}, dout, exp_nibble(off, JP2));
    if (!rd && resp) begin
      if (off == 'h48) begin m_cfg = 1; m_base = d[3:1]; end
      else if (off == 'h4C) m_cfg = 2;
      if (off == 'h48 || off == 'h4C) check({tag, ".cfg_edge"}, cfg_e, 3);
    end
    check({tag, ".base"}, BASE_RAM, m_base);
    check({tag, ".ram_cfg_n"}, RAM_CONFIGURED_n, (m_cfg != 1));
    check({tag, ".cfg_out_n"}, CONFIG_OUT_n, (m_cfg == 0));
  endtask

  initial begin
    logic [23:0] adr;
    logic [8:0]  mid;
    logic [6:0]  off7;
    logic [3:0]  d;
    int          seen;

    RESET_n = 1'b0; AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    A = '0; D_IN = '0; JP2 = 1'b1; CONFIG_IN_n = 1'b0;
    do_reset();

    check("rst.d_out", D_OUT, 4'h0);
    check("rst.d_oe", D_OE, 1'b0);
    check("rst.dtack_n", DTACK_n, 1'b1);
    check("rst.base", BASE_RAM, 3'b000);
    check("rst.ram_cfg_n", RAM_CONFIGURED_n, 1'b1);
    check("rst.cfg_out_n", CONFIG_OUT_n, 1'b1);

    CONFIG_IN_n = 1'b1;
    txn("chain_off_read", 24'hE80000, 1'b1, 4'h0, 1'b0);
    CONFIG_IN_n = 1'b0;

    JP2 = 1'b1;
    txn("type_hi_8m", 24'hE80000, 1'b1, 4'h0, 1'b0);
    txn("type_lo_8m", 24'hE80002, 1'b1, 4'h0, 1'b0);
    JP2 = 1'b0;
    txn("type_hi_4m", 24'hE80000, 1'b1, 4'h0, 1'b0);
    txn("type_lo_4m", 24'hE80002, 1'b1, 4'h0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      adr = 24'hE80010 + 24'(2 * i);
      txn($sformatf("manuf_%0d", i), adr, 1'b1, 4'h0, 1'b0);
    end
    txn("ofs40", 24'hE80040, 1'b1, 4'h0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      off7 = 7'($urandom_range(0, 63) * 2);
      mid  = 9'($urandom_range(0, 511));
      JP2  = 1'($urandom_range(0, 1));
      adr  = {8'hE8, mid, off7};
      if ($urandom_range(0, 3) == 0) adr[23:16] = 8'($urandom_range(0, 255)) & 8'hE7;
      txn($sformatf("rnd_rd_%0d", i), adr, 1'b1, 4'h0, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      off7 = 7'($urandom_range(0, 63) * 2);
      if (off7 == 7'h48 || off7 == 7'h4C) off7 = 7'h4A;
      mid = 9'($urandom_range(0, 511));
      d   = 4'($urandom_range(0, 15));
      txn($sformatf("rnd_wr_%0d", i), {8'hE8, mid, off7}, 1'b0, d, 1'b0);
    end

    txn("assign_base", 24'hE80048, 1'b0, 4'h2, 1'b0);
    check("assign_base.base_const", BASE_RAM, 3'b001);
    txn("read_after_cfg", 24'hE80000, 1'b1, 4'h0, 1'b0);

    do_reset();
    txn("shutup", 24'hE8004C, 1'b0, 4'h0, 1'b0);
    txn("wr48_after_shutup", 24'hE80048, 1'b0, 4'hE, 1'b0);
    check("shutup.base_const", BASE_RAM, 3'b000);

    do_reset();
    d = 4'($urandom_range(0, 15));
    txn("rnd_base", {8'hE8, 9'($urandom_range(0, 511)), 7'h48}, 1'b0, d, 1'b0);

    do_reset();
    adr = 24'hE80048;
    @(negedge CLK);
    A = adr[23:1]; RW_n = 1'b0; D_IN = 4'hA; AS_n = 1'b0; DS_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("mid.ack_cfg_out_n", CONFIG_OUT_n, 1'b0);
    check("mid.ack_base", BASE_RAM, 3'b101);
    check("mid.ack_dtack_n", DTACK_n, 1'b1);
    @(negedge CLK);
    RESET_n = 1'b0;
    @(posedge CLK); #1;
    check("mid.rst_d_out", D_OUT, 4'h0);
    check("mid.rst_d_oe", D_OE, 1'b0);
    check("mid.rst_dtack_n", DTACK_n, 1'b1);
    check("mid.rst_base", BASE_RAM, 3'b000);
    check("mid.rst_ram_cfg_n", RAM_CONFIGURED_n, 1'b1);
    check("mid.rst_cfg_out_n", CONFIG_OUT_n, 1'b1);
    @(negedge CLK);
    AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
    m_cfg = 0; m_base = 3'b000;

    seen = 0;
    RW_n = 1'b0; D_IN = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      DS_n = ~DS_n;
      @(posedge CLK); #1;
      if (D_OE || !DTACK_n || !CONFIG_OUT_n || BASE_RAM != 3'b000) seen++;
    end
    @(negedge CLK);
    DS_n = 1'b1; RW_n = 1'b1;
    check("ds_only.activity", seen, 0);
    check("ds_only.ram_cfg_n", RAM_CONFIGURED_n, 1'b1);

    JP2 = 1'b1;
    txn("chain_drop_cur", 24'hE80000, 1'b1, 4'h0, 1'b1);
    check("chain_drop.cfg_in", CONFIG_IN_n, 1'b1);
    txn("chain_drop_next", 24'hE80000, 1'b1, 4'h0, 1'b0);
    CONFIG_IN_n = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
